// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// master is the fetch unit side; slave is the memory/decode environment side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [31:0]           imem_rdata_i;
    logic                  branch_i;
    logic [ADDR_WIDTH-1:0] branch_target_i;
    logic                  instr_valid_o;
    logic [31:0]           instr_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;
    logic [ADDR_WIDTH-1:0] instr_next_pc_o;
    logic                  instr_ready_i;
    logic [CW-1:0]         count_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
               instr_next_pc_o, count_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_i,
               branch_target_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
               instr_next_pc_o, count_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_i,
               branch_target_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one memory request
// in flight and queues returned words in an in-order buffer drained by decode.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic          clk,
    input logic          reset_i,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  outstanding_q, outstanding_d;
    logic                  discard_q, discard_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d [DEPTH];
    logic [31:0]           word_mem_q [DEPTH];
    logic [31:0]           word_mem_d [DEPTH];

    logic        req, grant, resp, push, pop;
    logic [CW:0] occupancy;

    // The in-flight request reserves a slot so a response can always be accepted.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
        req   = !reset_i && (occupancy < DEPTH_W) && (!outstanding_q || bus.imem_rvalid_i);
        grant = req && bus.imem_gnt_i;
        resp  = outstanding_q && bus.imem_rvalid_i;
        push  = resp && !discard_q && !bus.branch_i;
        pop   = (count_q != '0) && bus.instr_ready_i && !bus.branch_i;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        pc_mem_d      = pc_mem_q;
        word_mem_d    = word_mem_q;

        if (grant) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        if (resp && discard_q) begin
            discard_d = 1'b0;
        end

        if (push) begin
            pc_mem_d[wr_ptr_q]   = req_pc_q;
            word_mem_d[wr_ptr_q] = bus.imem_rdata_i;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A request still in flight after a redirect belongs to the old path.
        if (bus.branch_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = bus.branch_target_i & ~ADDR_WIDTH'(3);
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        word_mem_q <= word_mem_d;
        if (reset_i) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    assign bus.imem_req_o      = req;
    assign bus.imem_addr_o     = fetch_pc_q;
    assign bus.instr_valid_o   = (count_q != '0);
    assign bus.instr_o         = word_mem_q[rd_ptr_q];
    assign bus.instr_pc_o      = pc_mem_q[rd_ptr_q];
    assign bus.instr_next_pc_o = pc_mem_q[rd_ptr_q] + ADDR_WIDTH'(4);
    assign bus.count_o         = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table for fetch_unit corner cases, then a randomized run
// against a queue-based reference model of the fetch/buffer behaviour.
module tb_fetch_unit;
    localparam int              AW       = 8;
    localparam int              DEPTH    = 4;
    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]   RESET_PC = 8'h00;
    localparam int              RND_CYCLES = 10000;

    typedef struct {
        bit            rst, gnt, rv, rdy, br;
        logic [AW-1:0] tgt;
        bit            e_req;
        logic [AW-1:0] e_addr;
        bit            e_valid;
        logic [AW-1:0] e_pc, e_npc;
        int            e_cnt;
    } vec_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   word;
    } ent_t;

    logic clk = 1'b0;
    logic reset_i;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    fetch_unit #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic vec_t mk(input int rst, gnt, rv, rdy, br, tgt,
                                input int e_req, e_addr, e_valid, e_pc, e_cnt);
        vec_t v;
        v.rst     = rst[0];
        v.gnt     = gnt[0];
        v.rv      = rv[0];
        v.rdy     = rdy[0];
        v.br      = br[0];
        v.tgt     = tgt[AW-1:0];
        v.e_req   = e_req[0];
        v.e_addr  = e_addr[AW-1:0];
        v.e_valid = e_valid[0];
        v.e_pc    = e_pc[AW-1:0];
        v.e_npc   = e_pc[AW-1:0] + AW'(4);
        v.e_cnt   = e_cnt;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, gnt, rv, input logic [31:0] rdata,
                                 input logic rdy, br, input logic [AW-1:0] tgt);
        reset_i             = rst;
        bus.imem_gnt_i      = gnt;
        bus.imem_rvalid_i   = rv;
        bus.imem_rdata_i    = rdata;
        bus.instr_ready_i   = rdy;
        bus.branch_i        = br;
        bus.branch_target_i = tgt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    vec_t          vecs[$];
    ent_t          m_q[$];
    ent_t          e;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] m_pc, m_rpc, last_pc;
    logic [31:0]   m_rword;
    bit            m_out, m_squash, have_last, exp_req, grant, pop_now;
    bit            rst, gnt, rv, rdy, br;
    logic [AW-1:0] tgt;
    int            m_due;

    initial begin
        // reset; k=1 streaming
        vecs.push_back(mk(0,1,0,1,0,0,     1,'h00, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h04, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h08, 1,'h00, 1));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h0C, 1,'h04, 1));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h10, 1,'h08, 1));
        vecs.push_back(mk(1,1,1,1,0,0,     0,0,    1,'h0C, 1));
        // fill with ready low, single pop
        vecs.push_back(mk(0,1,0,0,0,0,     1,'h00, 0,0,    0));
        vecs.push_back(mk(0,1,1,0,0,0,     1,'h04, 0,0,    0));
        vecs.push_back(mk(0,1,1,0,0,0,     1,'h08, 1,'h00, 1));
        vecs.push_back(mk(0,1,1,0,0,0,     1,'h0C, 1,'h00, 2));
        vecs.push_back(mk(0,1,1,0,0,0,     0,0,    1,'h00, 3));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,    1,'h00, 4));
        vecs.push_back(mk(0,1,0,1,0,0,     0,0,    1,'h00, 4));
        vecs.push_back(mk(0,1,0,0,0,0,     1,'h10, 1,'h04, 3));
        vecs.push_back(mk(0,1,1,0,0,0,     0,0,    1,'h04, 3));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,    1,'h04, 4));
        vecs.push_back(mk(1,0,0,0,0,0,     0,0,    1,'h04, 4));
        // branch while request to 0x10 is in flight
        vecs.push_back(mk(0,1,0,1,0,0,     1,'h00, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h04, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h08, 1,'h00, 1));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h0C, 1,'h04, 1));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h10, 1,'h08, 1));
        vecs.push_back(mk(0,1,0,1,1,'h41,  0,0,    1,'h0C, 1));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h40, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h44, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h48, 1,'h40, 1));
        vecs.push_back(mk(1,0,0,0,0,0,     0,0,    1,'h44, 1));
        // branch coincident with rvalid, grant and pop
        vecs.push_back(mk(0,1,0,1,0,0,     1,'h00, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h04, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h08, 1,'h00, 1));
        vecs.push_back(mk(0,1,1,1,1,'h80,  1,'h0C, 1,'h04, 1));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h80, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h84, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h88, 1,'h80, 1));
        vecs.push_back(mk(1,0,0,0,0,0,     0,0,    1,'h84, 1));
        // address wrap at top of the space
        vecs.push_back(mk(0,0,0,1,1,'hF9,  1,'h00, 0,0,    0));
        vecs.push_back(mk(0,1,0,1,0,0,     1,'hF8, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'hFC, 0,0,    0));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h00, 1,'hF8, 1));
        vecs.push_back(mk(0,1,1,0,0,0,     1,'h04, 1,'hFC, 1));
        vecs.push_back(mk(0,1,1,1,0,0,     1,'h08, 1,'hFC, 2));

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        mem_addr = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst, vecs[i].gnt, vecs[i].rv, word_of(mem_addr),
                          vecs[i].rdy, vecs[i].br, vecs[i].tgt);
            #1;
            checkOutput($sformatf("vec%0d_req", i), 32'(bus.imem_req_o), 32'(vecs[i].e_req));
            if (vecs[i].e_req)
                checkOutput($sformatf("vec%0d_addr", i), 32'(bus.imem_addr_o), 32'(vecs[i].e_addr));
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.instr_valid_o), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                checkOutput($sformatf("vec%0d_pc", i), 32'(bus.instr_pc_o), 32'(vecs[i].e_pc));
                checkOutput($sformatf("vec%0d_npc", i), 32'(bus.instr_next_pc_o), 32'(vecs[i].e_npc));
                checkOutput($sformatf("vec%0d_instr", i), bus.instr_o, word_of(vecs[i].e_pc));
            end
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count_o), 32'(vecs[i].e_cnt));
            if (!vecs[i].rst && vecs[i].gnt && vecs[i].e_req)
                mem_addr = vecs[i].e_addr;
        end

        // Randomized run: the memory and buffer contents live in the model below.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
        @(negedge clk);
        m_q.delete();
        m_pc = RESET_PC; m_out = 0; m_squash = 0; m_due = 0; have_last = 0;
        m_rpc = '0; m_rword = '0; last_pc = '0;

        for (int cyc = 0; cyc < RND_CYCLES; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(999) == 0);
            rv  = m_out && (m_due == cyc) && !rst;
            gnt = ($urandom_range(9) < 7);
            rdy = ($urandom_range(9) < 6);
            br  = ($urandom_range(19) == 0);
            tgt = AW'($urandom);
            applyStimulus(rst, gnt, rv, rv ? m_rword : $urandom, rdy, br, tgt);
            #1;
            exp_req = !rst && (m_q.size() + int'(m_out) < DEPTH) && (!m_out || rv);
            checkOutput($sformatf("rnd_req@%0d", cyc), 32'(bus.imem_req_o), 32'(exp_req));
            if (exp_req)
                checkOutput($sformatf("rnd_addr@%0d", cyc), 32'(bus.imem_addr_o), 32'(m_pc));
            checkOutput($sformatf("rnd_valid@%0d", cyc), 32'(bus.instr_valid_o), 32'(m_q.size() > 0));
            checkOutput($sformatf("rnd_count@%0d", cyc), 32'(bus.count_o), 32'(m_q.size()));
            checkOutput($sformatf("rnd_cnt_bound@%0d", cyc), 32'(int'(bus.count_o) <= DEPTH), 32'd1);
            if (m_q.size() > 0) begin
                checkOutput($sformatf("rnd_pc@%0d", cyc), 32'(bus.instr_pc_o), 32'(m_q[0].pc));
                checkOutput($sformatf("rnd_instr@%0d", cyc), bus.instr_o, m_q[0].word);
                checkOutput($sformatf("rnd_npc@%0d", cyc), 32'(bus.instr_next_pc_o),
                            32'(AW'(m_q[0].pc + AW'(4))));
            end

            if (rst) begin
                m_q.delete();
                m_pc = RESET_PC; m_out = 0; m_squash = 0; have_last = 0;
            end else begin
                grant   = exp_req && gnt;
                pop_now = !br && rdy && (m_q.size() > 0);
                if (pop_now) begin
                    if (have_last)
                        checkOutput($sformatf("rnd_contig@%0d", cyc), 32'(bus.instr_pc_o),
                                    32'(AW'(last_pc + AW'(4))));
                    last_pc   = m_q[0].pc;
                    have_last = 1;
                    void'(m_q.pop_front());
                end
                if (rv) begin
                    if (!m_squash && !br) begin
                        e.pc   = m_rpc;
                        e.word = m_rword;
                        m_q.push_back(e);
                    end
                    m_out = 0;
                end
                if (grant) begin
                    m_out    = 1;
                    m_squash = 0;
                    m_rpc    = m_pc;
                    m_rword  = $urandom;
                    m_due    = cyc + int'($urandom_range(5, 1));
                    m_pc     = m_pc + AW'(4);
                end
                if (br) begin
                    m_q.delete();
                    if (m_out) m_squash = 1;
                    m_pc      = {tgt[AW-1:2], 2'b00};
                    have_last = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
